// File: rtl/fx2_packet_echo_if.sv
// FX2 slave-FIFO bus bundle.
// master: the FPGA side (fx2_packet_echo). It drives the strobes, the address
//         and the outbound data, and receives the flags and the inbound data.
// slave : the FX2 side. It drives the flags and the inbound data.
// Signals: FIFO_rx_avail (OUT FIFO not empty), FIFO_tx_ready (IN FIFO not full),
//          FIFO_DATAIN/FIFO_DATAOUT (data bus halves), FIFO_RD/FIFO_WR/FIFO_PKTEND
//          (strobes), FIFO_DATAIN_OE/FIFO_DATAOUT_OE (bus direction),
//          FIFO_FIFOADR (endpoint select).
interface fx2_packet_echo_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              FIFO_rx_avail;
   logic              FIFO_tx_ready;
   logic [DATA_W-1:0] FIFO_DATAIN;
   logic [DATA_W-1:0] FIFO_DATAOUT;
   logic              FIFO_RD;
   logic              FIFO_WR;
   logic              FIFO_PKTEND;
   logic              FIFO_DATAIN_OE;
   logic              FIFO_DATAOUT_OE;
   logic [1:0]        FIFO_FIFOADR;

   modport master (
      input  FIFO_rx_avail, FIFO_tx_ready, FIFO_DATAIN,
      output FIFO_DATAOUT, FIFO_RD, FIFO_WR, FIFO_PKTEND,
             FIFO_DATAIN_OE, FIFO_DATAOUT_OE, FIFO_FIFOADR
   );

   modport slave (
      output FIFO_rx_avail, FIFO_tx_ready, FIFO_DATAIN,
      input  FIFO_DATAOUT, FIFO_RD, FIFO_WR, FIFO_PKTEND,
             FIFO_DATAIN_OE, FIFO_DATAOUT_OE, FIFO_FIFOADR
   );
endinterface

// File: rtl/fx2_packet_echo.sv
// FX2 packet echo. The block reads one OUT-endpoint packet into a local buffer.
// It then answers on the IN endpoint with the data echoed, the data inverted,
// or the received word count, and closes the response with PKTEND when the FX2
// will not commit the packet on its own.
// Ports:
//   FX2_CLK, FX2_RSTn : clock (rising edge), async active-low reset
//   MODE              : 0/3 echo, 1 byte count, 2 inverted echo; latched on leaving IDLE
//   fifo (master)     : FX2 slave-FIFO bus, see fx2_packet_echo_if
//   pkt_done_cnt      : completed responses, wraps at 8 bits
//   last_len          : word count of the last received packet
//   overflow          : sticky, set when a packet was cut at BUF_DEPTH words
//   busy              : state is not IDLE
module fx2_packet_echo #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BUF_DEPTH = 512,
   parameter int unsigned COUNT_W   = 16,
   parameter logic [1:0]  RX_ADDR   = 2'b00,
   parameter logic [1:0]  TX_ADDR   = 2'b10,
   parameter int unsigned PKT_SIZE  = 512
) (
   input  logic               FX2_CLK,
   input  logic               FX2_RSTn,
   input  logic [1:0]         MODE,
   fx2_packet_echo_if.master  fifo,
   output logic [7:0]         pkt_done_cnt,
   output logic [COUNT_W-1:0] last_len,
   output logic               overflow,
   output logic               busy
);

   localparam int unsigned ADDR_W    = $clog2(BUF_DEPTH);
   localparam int unsigned PTR_W     = ADDR_W + 1;
   localparam int unsigned CNT_WORDS = COUNT_W / DATA_W;
   localparam logic [COUNT_W-1:0] CNT_WORDS_W = COUNT_W'(CNT_WORDS);
   localparam logic [COUNT_W-1:0] PKT_SIZE_W  = COUNT_W'(PKT_SIZE);
   localparam logic [1:0] MODE_CNT = 2'd1;
   localparam logic [1:0] MODE_INV = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_RX, S_TURN, S_TX, S_END} state_t;

   state_t             state, state_d;
   logic [1:0]         mode_q;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [COUNT_W-1:0] len, tx_cnt;
   logic [DATA_W-1:0]  mem [BUF_DEPTH];

   logic               buf_full, buf_empty, src_pending;
   logic [COUNT_W-1:0] len_shift;
   logic [DATA_W-1:0]  head, tx_word;
   logic               rd_c, wr_c, pktend_c, din_oe_c, dout_oe_c;
   logic [1:0]         adr_c;
   logic [DATA_W-1:0]  dout_c;

   // Extra pointer bit separates a full buffer from an empty one.
   assign buf_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign buf_empty = (wr_ptr == rd_ptr);

   // Response word source: show-ahead buffer head, or last_len one word at a time.
   assign head        = mem[rd_ptr[ADDR_W-1:0]];
   assign len_shift   = last_len >> (DATA_W * 32'(tx_cnt));
   assign src_pending = (mode_q == MODE_CNT) ? (tx_cnt < CNT_WORDS_W) : !buf_empty;

   always_comb begin
      tx_word = head;
      if (mode_q == MODE_CNT)      tx_word = len_shift[DATA_W-1:0];
      else if (mode_q == MODE_INV) tx_word = ~head;
   end

   // Next state and bus decode.
   always_comb begin
      state_d   = state;
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      pktend_c  = 1'b0;
      din_oe_c  = 1'b1;
      dout_oe_c = 1'b0;
      adr_c     = RX_ADDR;
      dout_c    = '0;
      unique case (state)
         S_IDLE: begin
            if (fifo.FIFO_rx_avail) state_d = S_RX;
         end
         S_RX: begin
            rd_c = fifo.FIFO_rx_avail && !buf_full;
            if (!fifo.FIFO_rx_avail || buf_full) state_d = S_TURN;
         end
         S_TURN: begin
            adr_c    = TX_ADDR;
            din_oe_c = 1'b0;
            state_d  = S_TX;
         end
         S_TX: begin
            adr_c     = TX_ADDR;
            din_oe_c  = 1'b0;
            dout_oe_c = 1'b1;
            dout_c    = tx_word;
            wr_c      = fifo.FIFO_tx_ready && src_pending;
            if (!src_pending) state_d = S_END;
         end
         S_END: begin
            adr_c    = TX_ADDR;
            din_oe_c = 1'b0;
            // A nonzero multiple of PKT_SIZE has been committed by the FX2 already.
            pktend_c = (tx_cnt == '0) || ((tx_cnt % PKT_SIZE_W) != '0);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fifo.FIFO_RD           = rd_c;
   assign fifo.FIFO_WR           = wr_c;
   assign fifo.FIFO_PKTEND       = pktend_c;
   assign fifo.FIFO_DATAIN_OE    = din_oe_c;
   assign fifo.FIFO_DATAOUT_OE   = dout_oe_c;
   assign fifo.FIFO_FIFOADR      = adr_c;
   assign fifo.FIFO_DATAOUT      = dout_c;
   assign busy                   = (state != S_IDLE);

   // State, pointers, counters and status.
   always_ff @(posedge FX2_CLK or negedge FX2_RSTn) begin
      if (!FX2_RSTn) begin
         state        <= S_IDLE;
         mode_q       <= 2'd0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         len          <= '0;
         tx_cnt       <= '0;
         last_len     <= '0;
         overflow     <= 1'b0;
         pkt_done_cnt <= 8'd0;
      end else begin
         state <= state_d;
         unique case (state)
            S_IDLE: begin
               if (fifo.FIFO_rx_avail) begin
                  mode_q <= (MODE == 2'd3) ? 2'd0 : MODE;
                  len    <= '0;
               end
            end
            S_RX: begin
               if (rd_c) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
                  if (len != '1) len <= len + COUNT_W'(1);
               end
               if (fifo.FIFO_rx_avail && buf_full) overflow <= 1'b1;
            end
            S_TURN: begin
               last_len <= len;
               tx_cnt   <= '0;
               if (mode_q == MODE_CNT) begin
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end
            end
            S_TX: begin
               if (wr_c) begin
                  tx_cnt <= tx_cnt + COUNT_W'(1);
                  if (mode_q != MODE_CNT) rd_ptr <= rd_ptr + PTR_W'(1);
               end
            end
            S_END: pkt_done_cnt <= pkt_done_cnt + 8'd1;
            default: ;
         endcase
      end
   end

   // Packet storage; contents need no reset.
   always_ff @(posedge FX2_CLK) begin
      if (rd_c) mem[wr_ptr[ADDR_W-1:0]] <= fifo.FIFO_DATAIN;
   end

endmodule

// File: tb/tb_fx2_packet_echo.sv
// Bench for fx2_packet_echo: an FX2-side model feeds OUT packets and randomly
// stalls the IN FIFO, a reference model queues the expected IN stream, and a
// monitor checks every written word and every PKTEND pulse against it.
module tb_fx2_packet_echo;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BUF_DEPTH = 256;
   localparam int unsigned COUNT_W   = 16;
   localparam int unsigned PKT_SIZE  = 4;
   localparam int          CW        = COUNT_W / DATA_W;
   localparam int          MASK      = (1 << DATA_W) - 1;
   localparam int          END_TOK   = -1;
   localparam int          NONE_TOK  = -2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         mode = 2'd0;
   logic [7:0]         pkt_done_cnt;
   logic [COUNT_W-1:0] last_len;
   logic               overflow;
   logic               busy;

   fx2_packet_echo_if #(.DATA_W(DATA_W)) fifo ();

   fx2_packet_echo #(
      .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .COUNT_W(COUNT_W),
      .RX_ADDR(2'b00), .TX_ADDR(2'b10), .PKT_SIZE(PKT_SIZE)
   ) dut (
      .FX2_CLK(clk), .FX2_RSTn(rst_n), .MODE(mode), .fifo(fifo),
      .pkt_done_cnt(pkt_done_cnt), .last_len(last_len),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int rx_q[$];
   int exp_q[$];
   int pkt[$];
   int exp_done = 0;
   int exp_last = 0;
   bit exp_ovf = 1'b0;
   int stall_pct = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // FX2 side: OUT FIFO pops on RD at the edge, IN FIFO readiness is random.
   initial begin : fx2_model
      bit rd_s;
      fifo.FIFO_rx_avail = 1'b0;
      fifo.FIFO_tx_ready = 1'b1;
      fifo.FIFO_DATAIN   = '0;
      forever begin
         @(negedge clk);
         rd_s = fifo.FIFO_RD;
         @(posedge clk);
         #1;
         if (rd_s && rx_q.size() > 0) void'(rx_q.pop_front());
         fifo.FIFO_rx_avail = (rx_q.size() > 0);
         fifo.FIFO_DATAIN   = (rx_q.size() > 0) ? DATA_W'(rx_q[0]) : '0;
         fifo.FIFO_tx_ready = ($urandom_range(99) >= stall_pct);
      end
   end

   // Monitor: every WR word and every PKTEND pulse pops the expected stream.
   initial begin : monitor
      int tok;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (fifo.FIFO_RD)
               check("rd_bus_dir", int'({fifo.FIFO_DATAIN_OE, fifo.FIFO_FIFOADR}), 4);
            if (fifo.FIFO_WR) begin
               tok = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOK;
               check("wr_data", int'(fifo.FIFO_DATAOUT), tok);
               check("wr_bus_dir", int'({fifo.FIFO_DATAOUT_OE, fifo.FIFO_DATAIN_OE,
                                        fifo.FIFO_FIFOADR}), 10);
            end
            if (fifo.FIFO_PKTEND) begin
               tok = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOK;
               check("pktend", END_TOK, tok);
               check("pktend_addr", int'(fifo.FIFO_FIFOADR), 2);
            end
         end
      end
   end

   // Reference: the packet splits into responses of at most BUF_DEPTH words.
   task automatic expect_packet(input int m);
      int rem, idx, c, words;
      rem = pkt.size();
      idx = 0;
      while (rem > 0) begin
         c = (rem > int'(BUF_DEPTH)) ? int'(BUF_DEPTH) : rem;
         if (m == 1) begin
            for (int k = 0; k < CW; k++) exp_q.push_back((c >> (int'(DATA_W) * k)) & MASK);
            words = CW;
         end else begin
            for (int k = 0; k < c; k++)
               exp_q.push_back((m == 2) ? (~pkt[idx + k]) & MASK : pkt[idx + k]);
            words = c;
         end
         if (words % int'(PKT_SIZE) != 0) exp_q.push_back(END_TOK);
         exp_done = (exp_done + 1) % 256;
         exp_last = c;
         idx += c;
         rem -= c;
      end
      if (pkt.size() > int'(BUF_DEPTH)) exp_ovf = 1'b1;
   endtask

   task automatic load_packet(input int m);
      mode = 2'(m);
      @(posedge clk);
      #2;
      foreach (pkt[i]) rx_q.push_back(pkt[i]);
   endtask

   task automatic run_packet(input int m);
      int t;
      expect_packet(m);
      load_packet(m);
      t = 0;
      while (t < 20000 && !(pkt_done_cnt == 8'(exp_done) && !busy && rx_q.size() == 0)) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("pkt_done_cnt", int'(pkt_done_cnt), exp_done);
      check("last_len", int'(last_len), exp_last);
      check("overflow", int'(overflow), int'(exp_ovf));
      check("busy_after", int'(busy), 0);
      check("leftover_expected", exp_q.size(), 0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_strobes"}, int'({fifo.FIFO_RD, fifo.FIFO_WR, fifo.FIFO_PKTEND,
                                    fifo.FIFO_DATAOUT_OE}), 0);
      check({tag, "_datain_oe"}, int'(fifo.FIFO_DATAIN_OE), 1);
      check({tag, "_fifoadr"}, int'(fifo.FIFO_FIFOADR), 0);
      check({tag, "_dataout"}, int'(fifo.FIFO_DATAOUT), 0);
      check({tag, "_counters"}, int'({pkt_done_cnt, last_len, overflow, busy}), 0);
   endtask

   task automatic random_packet(input int n);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(int'($urandom_range(MASK)));
   endtask

   initial begin : main
      int t;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Plain echo.
      stall_pct = 0;
      pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_packet(0);

      // Byte count above 255 words, with overflow into a second response.
      random_packet(300);
      run_packet(1);

      // Inverted echo under heavy IN-FIFO backpressure.
      stall_pct = 60;
      pkt = '{8'hAA, 8'h55, 8'h0F};
      run_packet(2);

      // Exact multiple of the IN packet size: no PKTEND.
      stall_pct = 20;
      random_packet(8);
      run_packet(0);

      // Packet exactly filling the buffer, then one just over it.
      random_packet(BUF_DEPTH);
      run_packet(3);
      random_packet(BUF_DEPTH + 4);
      run_packet(0);

      // Random traffic.
      stall_pct = 25;
      for (int p = 0; p < 30; p++) begin
         random_packet(($urandom_range(9) == 0) ? int'($urandom_range(1, 300))
                                                : int'($urandom_range(1, 20)));
         run_packet(int'($urandom_range(3)));
      end

      // Reset in the middle of a response, then recover.
      random_packet(40);
      expect_packet(0);
      load_packet(0);
      t = 0;
      while (t < 2000 && !fifo.FIFO_DATAOUT_OE) begin
         @(negedge clk);
         t++;
      end
      check("reached_tx", int'(fifo.FIFO_DATAOUT_OE), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      rx_q.delete();
      exp_q.delete();
      exp_done = 0;
      exp_ovf  = 1'b0;
      #1;
      reset_checks("midtx_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      random_packet(1);
      run_packet(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
